// File: rtl/fb_pkg.sv
// fb_pkg: sizing helpers shared by the node-side merger and its lane FIFOs
package fb_pkg;
  function automatic int nodeCount(input int perRow, input int perCol);
    return perRow * perCol;
  endfunction
  function automatic int ptrW(input int depth);
    return $clog2(depth);
  endfunction
  // One extra bit so a full FIFO is distinguishable from an empty one
  function automatic int cntW(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int slice_lsb(input int n, input int dataW);
    return n * dataW;
  endfunction
endpackage

// File: rtl/node_fifo.sv
// node_fifo: single-lane FIFO with occupancy count, full/empty decode and sticky overflow
module node_fifo
  import fb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wrData,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head,
  output logic [cntW(DEPTH)-1:0]  count,
  output logic                    empty,
  output logic                    overflow
);
  localparam int PW = ptrW(DEPTH);
  localparam int CW = cntW(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic full, doPush, doPop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign head = mem[rdPtr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
      overflow <= overflow | (push && full);
    end
  end
endmodule

// File: rtl/data_merger.sv
// data_merger: per-node FIFOs feeding flattened valid/data vectors, with per-node backpressure
module data_merger
  import fb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int N = nodeCount(NODE_PER_ROW, NODE_PER_COL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i_node [0:N-1],
  input  logic [0:DATA_W-1]     data_i_node [0:N-1],
  input  logic [0:N-1]          off_sigs_i_NoC,
  output logic                  off_sigs_o_node [0:N-1],
  output logic [0:N-1]          valid_o_NoC,
  output logic [0:DATA_W*N-1]   data_o_NoC,
  output logic [0:N-1]          overflow_o
);
  localparam int CW = cntW(FIFO_DEPTH);
  logic [DATA_W-1:0] head [N];
  logic [CW-1:0] count [N];
  logic [0:N-1] empty, pop;
  for (genvar n = 0; n < N; n++) begin : lane
    assign pop[n] = !empty[n] && !off_sigs_i_NoC[n];
    // One word of headroom covers a source that reacts a cycle late
    assign off_sigs_o_node[n] = count[n] >= CW'(FIFO_DEPTH - 1);
    node_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
      .clk,
      .rst,
      .push(valid_i_node[n]),
      .wrData(data_i_node[n]),
      .pop(pop[n]),
      .head(head[n]),
      .count(count[n]),
      .empty(empty[n]),
      .overflow(overflow_o[n])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o_NoC <= '0;
      data_o_NoC <= '0;
    end else begin
      valid_o_NoC <= pop;
      for (int n = 0; n < N; n++)
        if (pop[n]) data_o_NoC[slice_lsb(n, DATA_W) +: DATA_W] <= head[n];
    end
  end
endmodule
